// File: rtl/bus_datapath_pkg.sv
// rtl/bus_datapath_pkg.sv - shared types and constants for the single-bus datapath
package bus_datapath_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        SHL = 4'd4,
        SHR = 4'd5,
        SRA = 4'd6,
        MUL = 4'd7,
        NEG = 4'd8,
        NOT = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T_Y  = 2'd1,
        ST_T_Z  = 2'd2,
        ST_T_WB = 2'd3
    } state_t;

    // Bus source indices; lower index wins if several were ever enabled.
    localparam int SRC_EXT = 0;
    localparam int SRC_RA  = 1;
    localparam int SRC_RB  = 2;
    localparam int SRC_Z   = 3;
    localparam int NUM_SRC = 4;

    // Opcodes above NOT have no ALU function and must not write back.
    function automatic logic op_illegal(input logic [3:0] op);
        return op > 4'd9;
    endfunction

endpackage

// File: rtl/bus_src_encoder.sv
// rtl/bus_src_encoder.sv - one-hot out-enable priority encoder and bus mux
module bus_src_encoder #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]        en_i,
    input  logic [N-1:0][W-1:0] data_i,
    output logic [W-1:0]        bus_o
);

    // Scan from the top down so the lowest enabled index is the last assignment.
    always_comb begin
        bus_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_i[i]) begin
                bus_o = data_i[i];
            end
        end
    end

endmodule

// File: rtl/bus_datapath_seq.sv
// rtl/bus_datapath_seq.sv - single-bus datapath with built-in four-step instruction sequencer
module bus_datapath_seq
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rc,
    input  logic             ext_wr_en,
    input  logic [AW-1:0]    ext_wr_addr,
    input  logic [WIDTH-1:0] ext_wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    state_t                         state_q, state_d;
    logic [3:0]                     op_q;
    logic [AW-1:0]                  ra_q, rb_q, rc_q;
    logic [WIDTH-1:0]               regs_q [NUM_REGS];
    logic [WIDTH-1:0]               y_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]             z_q;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;

    logic                           latch_instr;
    logic                           wr_en;
    logic [AW-1:0]                  wr_addr;
    logic                           hilo_wr;
    logic                           illegal;

    logic [NUM_SRC-1:0]             bus_oe;
    logic [NUM_SRC-1:0][WIDTH-1:0]  bus_srcs;
    logic [WIDTH-1:0]               bus;

    logic [SHW-1:0]                 shamt;
    logic [WIDTH-1:0]               alu_lo;
    logic [2*WIDTH-1:0]             prod;
    logic [2*WIDTH-1:0]             alu_z;

    assign illegal = op_illegal(op_q);

    // Each state enables exactly one bus driver; IDLE without a write leaves the bus at 0.
    always_comb begin
        bus_oe = '0;
        case (state_q)
            ST_IDLE: if (!start && ext_wr_en) bus_oe[SRC_EXT] = 1'b1;
            ST_T_Y:  bus_oe[SRC_RA] = 1'b1;
            ST_T_Z:  bus_oe[SRC_RB] = 1'b1;
            ST_T_WB: bus_oe[SRC_Z]  = 1'b1;
            default: bus_oe = '0;
        endcase
    end

    // Candidate bus drivers, indexed by the package source constants.
    always_comb begin
        bus_srcs          = '0;
        bus_srcs[SRC_EXT] = ext_wr_data;
        bus_srcs[SRC_RA]  = regs_q[ra_q];
        bus_srcs[SRC_RB]  = regs_q[rb_q];
        bus_srcs[SRC_Z]   = z_q[WIDTH-1:0];
    end

    bus_src_encoder #(
        .N (NUM_SRC),
        .W (WIDTH)
    ) u_bus_src (
        .en_i   (bus_oe),
        .data_i (bus_srcs),
        .bus_o  (bus)
    );

    // ALU: Y against the bus operand; non-multiply results are zero-extended into Z.
    always_comb begin
        shamt  = bus[SHW-1:0];
        prod   = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};
        alu_lo = '0;
        case (op_q)
            ADD:     alu_lo = y_q + bus;
            SUB:     alu_lo = y_q - bus;
            AND:     alu_lo = y_q & bus;
            OR:      alu_lo = y_q | bus;
            SHL:     alu_lo = y_q << shamt;
            SHR:     alu_lo = y_q >> shamt;
            SRA:     alu_lo = $unsigned($signed(y_q) >>> shamt);
            NEG:     alu_lo = '0 - bus;
            NOT:     alu_lo = ~bus;
            default: alu_lo = '0;
        endcase
        alu_z = (op_q == MUL) ? prod : {{WIDTH{1'b0}}, alu_lo};
    end

    // Sequencer: next state, status flags and write strobes for the current step.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        latch_instr = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = ext_wr_addr;
        hilo_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_instr = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_T_Y;
                end else if (ext_wr_en) begin
                    wr_en = 1'b1;
                end
            end
            ST_T_Y:  state_d = ST_T_Z;
            ST_T_Z:  state_d = ST_T_WB;
            ST_T_WB: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = illegal;
                wr_addr = rc_q;
                if (op_q == MUL) begin
                    hilo_wr = 1'b1;
                end else if (!illegal) begin
                    wr_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural state; reset clears everything and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch_instr) begin
                op_q <= op;
                ra_q <= ra;
                rb_q <= rb;
                rc_q <= rc;
            end
            if (state_q == ST_T_Y) begin
                y_q <= bus;
            end
            if (state_q == ST_T_Z) begin
                z_q <= alu_z;
            end
            if (hilo_wr) begin
                hi_q <= z_q[2*WIDTH-1:WIDTH];
                lo_q <= z_q[WIDTH-1:0];
            end
            if (wr_en) begin
                regs_q[wr_addr] <= bus;
            end
        end
    end

    assign rd_data = regs_q[rd_addr];
    assign bus_out = bus;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb/tb_bus_datapath_seq.sv - scoreboard bench for bus_datapath_seq
module tb_bus_datapath_seq;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk;
    logic          clr;
    logic          start;
    logic [3:0]    op;
    logic [AW-1:0] ra, rb, rc;
    logic          ext_wr_en;
    logic [AW-1:0] ext_wr_addr;
    logic [W-1:0]  ext_wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  bus_out;
    logic [W-1:0]  hi, lo;
    logic          busy, done, err;

    bus_datapath_seq #(.WIDTH(W), .NUM_REGS(N)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .ra          (ra),
        .rb          (rb),
        .rc          (rc),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .bus_out     (bus_out),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_hi, m_lo;

    typedef struct {
        logic         err;
        logic         chk_bus;
        logic [W-1:0] bus;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           scyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input int opc, input logic [31:0] a, input logic [31:0] b);
        int     sh;
        longint p;
        logic [31:0] r;
        sh = int'(b & 32'd31);
        case (opc)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a << sh;
            5: r = a >> sh;
            6: r = int'(a) >>> sh;
            7: begin
                p = longint'(int'(a)) * longint'(int'(b));
                return p;
            end
            8: r = 32'd0 - b;
            9: r = ~b;
            default: r = 32'd0;
        endcase
        return {32'h0, r};
    endfunction

    // Monitor: every done pulse consumes one expected completion.
    logic [W-1:0] prev_bus = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", 64'(cyc - e.scyc), 64'd3);
                    chk("err", {63'h0, err}, {63'h0, e.err});
                    chk("hi", {32'h0, hi}, {32'h0, e.hi});
                    chk("lo", {32'h0, lo}, {32'h0, e.lo});
                    if (e.chk_bus) chk("wb_bus", {32'h0, prev_bus}, {32'h0, e.bus});
                end
            end else if (err === 1'b1) begin
                chk("err_without_done", 64'd1, 64'd0);
            end
            prev_bus = bus_out;
        end
    end

    task automatic ext_write(input int a, input logic [W-1:0] d);
        ext_wr_en   = 1'b1;
        ext_wr_addr = AW'(a);
        ext_wr_data = d;
        #1;
        chk("ext_bus", {32'h0, bus_out}, {32'h0, d});
        @(posedge clk); #1;
        ext_wr_en = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic issue(input int opc, input int a, input int b, input int c,
                         input bit ext_same, input bit ext_busy, input bit chk_busy);
        exp_t        e;
        logic [63:0] z;
        start       = 1'b1;
        op          = 4'(opc);
        ra          = AW'(a);
        rb          = AW'(b);
        rc          = AW'(c);
        ext_wr_en   = ext_same;
        ext_wr_addr = AW'(c);
        ext_wr_data = $urandom;
        z = ref_alu(opc, m_regs[a], m_regs[b]);
        e.err     = (opc > 9);
        e.chk_bus = (opc <= 9);
        e.bus     = z[31:0];
        if (opc == 7) begin
            m_hi = z[63:32];
            m_lo = z[31:0];
        end else if (opc <= 9) begin
            m_regs[c] = z[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        @(posedge clk); #1;
        e.scyc = cyc;
        sb.push_back(e);
        start     = 1'b0;
        ext_wr_en = ext_busy;
        if (ext_busy) begin
            ext_wr_addr = AW'($urandom_range(0, N - 1));
            ext_wr_data = $urandom;
        end
        if (chk_busy) chk("busy_t_y", {63'h0, busy}, 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
            if (chk_busy) chk("busy_mid", {63'h0, busy}, 64'd1);
        end
        @(posedge clk); #1;
        ext_wr_en = 1'b0;
        if (chk_busy) begin
            chk("busy_done_cycle", {63'h0, busy}, 64'd0);
            chk("done_pulse", {63'h0, done}, 64'd1);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), {32'h0, rd_data}, {32'h0, m_regs[i]});
        end
    endtask

    task automatic check_reg_const(input string name, input int a, input logic [W-1:0] v);
        rd_addr = AW'(a);
        #1;
        chk(name, {32'h0, rd_data}, {32'h0, v});
    endtask

    initial begin
        int kind;
        int wait_cyc;
        clr = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; rd_addr = '0;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        check_regs("reset");
        chk("reset_hi", {32'h0, hi}, 64'd0);
        chk("reset_lo", {32'h0, lo}, 64'd0);
        chk("reset_busy", {63'h0, busy}, 64'd0);
        chk("reset_done", {63'h0, done}, 64'd0);
        chk("reset_bus", {32'h0, bus_out}, 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("idle_bus_zero", {32'h0, bus_out}, 64'd0);

        ext_write(1, 32'd5);
        ext_write(2, 32'd7);
        issue(0, 1, 2, 3, 1'b0, 1'b0, 1'b1);
        check_reg_const("add_r3", 3, 32'd12);

        ext_write(1, 32'hFFFF_FFFF);
        ext_write(2, 32'd2);
        issue(1, 2, 1, 4, 1'b0, 1'b0, 1'b1);
        check_reg_const("sub_wrap_r4", 4, 32'd3);
        issue(7, 1, 2, 0, 1'b0, 1'b0, 1'b0);
        chk("mul_hi", {32'h0, hi}, 64'hFFFF_FFFF);
        chk("mul_lo", {32'h0, lo}, 64'hFFFF_FFFE);
        check_regs("after_mul");

        ext_write(5, 32'h8000_0000);
        ext_write(6, 32'd33);
        issue(6, 5, 6, 7, 1'b0, 1'b0, 1'b0);
        issue(5, 5, 6, 8, 1'b0, 1'b0, 1'b0);
        check_reg_const("sra_r7", 7, 32'hC000_0000);
        check_reg_const("shr_r8", 8, 32'h4000_0000);

        issue(0, 1, 2, 9, 1'b1, 1'b0, 1'b0);
        issue(2, 3, 4, 10, 1'b0, 1'b1, 1'b1);
        issue(12, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        check_reg_const("illegal_r3_kept", 3, 32'd12);
        issue(0, 3, 3, 3, 1'b0, 1'b0, 1'b0);
        check_regs("directed");

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                ext_write($urandom_range(0, N - 1), $urandom);
            end else begin
                issue($urandom_range(0, 15), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                      $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        check_regs("random");

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd11;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_done", {63'h0, done}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done_later", {63'h0, done}, 64'd0);
        check_regs("abort");
        chk("abort_hi", {32'h0, hi}, 64'd0);
        chk("abort_lo", {32'h0, lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised successor of the single-bus 32-bit datapath.
- Holds a NUM_REGS x WIDTH general register file, the Y latch, a 2*WIDTH Z register and HI/LO registers, all on one shared internal bus.
- A built-in micro-step sequencer executes one register-register ALU instruction per start request: Ra->Y, Rb->ALU->Z, Z->Rc (or HI/LO).
- Feeds the future control unit; outside loading uses an external write port.

Parameters:
- WIDTH, 32, data and bus width in bits (>=8, power of two).
- NUM_REGS, 16, general register count (power of two, 2..32).
- AW, $clog2(NUM_REGS), register address width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-low reset.
- start  in  1  request one instruction; sampled only in IDLE.
- op  in  4  ALU opcode (package encoding).
- ra, rb, rc  in  AW  source A, source B, destination.
- ext_wr_en  in  1  external register write strobe.
- ext_wr_addr  in  AW  external write address.
- ext_wr_data  in  WIDTH  external write data.
- rd_addr  in  AW  debug read address.
- rd_data  out  WIDTH  combinational R[rd_addr].
- bus_out  out  WIDTH  current internal bus value.
- hi, lo  out  WIDTH  HI/LO register contents.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal opcode.

Behaviour:
- Reset (clr==0 at a rising edge): state IDLE; all registers, Y, Z, HI, LO cleared to 0; busy, done and err cleared to 0. Reset mid-instruction aborts it with no writeback and no done.
- States: IDLE -> T_Y -> T_Z -> T_WB -> IDLE.
- IDLE:
  - start==1: latch op, ra, rb, rc; go to T_Y; busy<=1. ext_wr_en in the same cycle is ignored (start wins).
  - start==0 and ext_wr_en==1: R[ext_wr_addr]<=ext_wr_data; bus = ext_wr_data.
  - Otherwise bus = 0.
- T_Y: bus = R[ra]; Y<=bus.
- T_Z: bus = R[rb]; Z<=ALU(Y, bus).
- T_WB:
  - Normal ops: bus = Z[WIDTH-1:0]; R[rc]<=bus.
  - MUL: HI<=Z[2W-1:W] and LO<=Z[W-1:0]; no register write; bus = Z low.
  - Illegal op: no writes.
  - In all cases: busy<=0, done<=1, err<=illegal; next state IDLE.
- Latency: start sampled at edge E0; result written at E3; done high for exactly the cycle after E3.
  - A new start may be sampled in that done cycle, giving back-to-back throughput of 1 instruction per 4 cycles.
  - done and err are forced to 0 in every other cycle.
- ext_wr_en while busy: ignored and dropped, not queued.
- Bus source selection: each state drives a one-hot out-enable vector to a priority encoder, which selects the lowest index. By construction exactly one (or zero) enable is active; zero enables give bus = 0.
- Read-before-write hazards: ra==rc and rb==rc are legal; reads complete in T_Y/T_Z, before T_WB.
- ALU arithmetic (Z is 2W; non-MUL results are zero-extended into Z high; all results wrap mod 2^W):
  - ADD: Y+B.
  - SUB: Y-B.
  - AND, OR: bitwise.
  - SHL: logical left; amount = B[log2(W)-1:0].
  - SHR: logical right; same amount rule.
  - SRA: arithmetic right; same amount rule.
  - MUL: signed W x W -> 2W.
  - NEG: 0-B.
  - NOT: ~B.
  - NEG and NOT ignore Y; Y is still loaded.
- Opcodes 10..15 are illegal: full 4-step sequence runs, no write, err=1 with done.

Decomposition:
- Package bus_datapath_pkg holds:
  - the op_t enum: ADD=0, SUB=1, AND=2, OR=3, SHL=4, SHR=5, SRA=6, MUL=7, NEG=8, NOT=9;
  - the state_t enum;
  - the bus-source index constants.
- Sub-module: bus_src_encoder, a parametrised one-hot-to-binary priority encoder plus mux.
- The ALU stays an always_comb block inside the top.

Test Plan:
- Reset/idle: clr low 1 cycle -> rd_data 0 for every register; hi=lo=0; busy=done=0; bus_out=0.
- ADD: ext write R1=5, R2=7; start op=ADD ra=1 rb=2 rc=3 -> busy 3 cycles, done at cycle 4, R3=12, err=0.
- Wrap and MUL (WIDTH=32): R1=0xFFFFFFFF, R2=2.
  - SUB ra=2 rb=1 rc=4 -> R4=3.
  - MUL ra=1 rb=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; no GPR changed.
- Shifts: R5=0x80000000, R6=33.
  - SRA ra=5 rb=6 rc=7 -> amount 1, R7=0xC0000000.
  - SHR -> 0x40000000.
- Collisions:
  - start with ext_wr_en in the same IDLE cycle -> ext write lost.
  - ext_wr_en during busy -> no change.
  - Illegal op=12 -> done with err=1, R[rc] unchanged.
  - Back-to-back start in the done cycle is accepted.
- Reset mid-op: clr low during T_Z -> no R[rc] write, no done; busy=0 the next cycle.
